// File: rtl/alu_muldiv.sv
// ----------------------------------------------------------------------------
// alu_muldiv
//
// Iterative RV32M multiply/divide unit for the execute stage. One operation is
// accepted over a valid/ready handshake, iterated for WIDTH cycles with a
// radix-2 shift-add multiplier or a restoring divider, and the registered
// result is held until the consumer pops it.
//
// Configuration macro:
//   ALU_MULDIV_EARLY_OUT_EN  when defined, these cases skip CALC and present
//                            their result one cycle after the accept:
//                              - divide by zero
//                              - signed overflow
//                              - multiply by zero
//                            The result values are the same either way.
//
// Parameters:
//   WIDTH      operand/result width; must be even and >= 4
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operands and func3 valid this cycle
//   in_ready   unit can accept an operation (IDLE only)
//   in1        rs1: multiplicand or dividend
//   in2        rs2: multiplier or divisor
//   func3      000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//              100 DIV, 101 DIVU, 110 REM,    111 REMU
//   out_valid  result and zero are valid
//   out_ready  consumer accepts the result
//   result     registered result
//   zero       registered, high iff result == 0
//   busy       high in CALC or DONE
// ----------------------------------------------------------------------------
module alu_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [2:0]       func3,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             busy
);

    localparam int              CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]   LAST     = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] ALL_ONES = {WIDTH{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    // Handshake events
    logic accept;
    logic pop;
    logic calc_last;

    // Operation captured on the accept edge
    logic [2:0]         op;
    logic               neg_q;        // negate product / quotient
    logic               neg_r;        // negate remainder (follows in1)
    logic               special_hit;
    logic [WIDTH-1:0]   special_val;
    logic [CW-1:0]      cnt;

    // Iteration datapath. For a multiply, acc = {partial sum, remaining
    // multiplier bits}; for a divide, acc = {partial remainder, dividend bits
    // still to shift in / quotient bits shifted in}. operand holds the
    // multiplicand magnitude or the divisor magnitude respectively.
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   operand;

    // ------------------------------------------------------------------------
    // Input decode (only meaningful in the accept cycle)
    // ------------------------------------------------------------------------
    logic             is_div;
    logic             a_signed;
    logic             b_signed;
    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic             div_zero;
    logic             div_ovf;
    logic             mul_zero;
    logic             special_now;
    logic [WIDTH-1:0] special_val_now;

    // NOTE: every signal written in an always_comb gets a default value first,
    // so no path through the block can leave it unassigned and infer a latch.
    always_comb begin
        is_div   = func3[2];
        a_signed = (func3 == 3'b001) || (func3 == 3'b010) ||
                   (func3 == 3'b100) || (func3 == 3'b110);
        b_signed = (func3 == 3'b001) || (func3 == 3'b100) || (func3 == 3'b110);
        a_neg    = a_signed && in1[WIDTH-1];
        b_neg    = b_signed && in2[WIDTH-1];
        a_mag    = a_neg ? -in1 : in1;
        b_mag    = b_neg ? -in2 : in2;

        div_zero = is_div && (in2 == '0);
        // Signed DIV/REM only (func3[0] clear selects the signed variants)
        div_ovf  = is_div && !func3[0] && (in1 == MOST_NEG) && (in2 == ALL_ONES);
        mul_zero = !is_div && ((in1 == '0) || (in2 == '0));

        special_now     = div_zero || div_ovf || mul_zero;
        special_val_now = '0;
        if (div_zero) begin
            special_val_now = func3[1] ? in1 : ALL_ONES;
        end else if (div_ovf) begin
            special_val_now = func3[1] ? '0 : in1;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples its inputs from the same pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
`ifdef ALU_MULDIV_EARLY_OUT_EN
                    state_next = special_now ? DONE : CALC;
`else
                    state_next = CALC;
`endif
                end
            end
            CALC: begin
                if (calc_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                if (pop) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------------
    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
        busy      = (state != IDLE);
        accept    = in_valid && in_ready;
        pop       = out_valid && out_ready;
        calc_last = (state == CALC) && (cnt == LAST);
    end

    // ------------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------------
    logic [WIDTH:0]     step_sum;
    logic [WIDTH:0]     step_shift;
    logic [WIDTH:0]     step_diff;
    logic [2*WIDTH-1:0] acc_next;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier bit is
        // set, then shift the whole accumulator right (carry included).
        step_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, operand} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // trial-subtract the divisor; a borrow means restore.
        step_shift = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
        step_diff  = step_shift - {1'b0, operand};

        if (op[2]) begin
            if (!step_diff[WIDTH]) begin
                acc_next = {step_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_next = {step_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_next = {step_sum, acc[WIDTH-1:1]};
        end
    end

    // ------------------------------------------------------------------------
    // Final write: restore signs and pick the requested half/quantity. Uses
    // acc_next so the last iteration and the write share one edge.
    // ------------------------------------------------------------------------
    logic [2*WIDTH-1:0] prod_signed;
    logic [WIDTH-1:0]   quo_signed;
    logic [WIDTH-1:0]   rem_signed;
    logic [WIDTH-1:0]   final_val;

    always_comb begin
        prod_signed = neg_q ? -acc_next : acc_next;
        quo_signed  = neg_q ? -acc_next[WIDTH-1:0] : acc_next[WIDTH-1:0];
        rem_signed  = neg_r ? -acc_next[2*WIDTH-1:WIDTH] : acc_next[2*WIDTH-1:WIDTH];

        case (op)
            3'b000:                 final_val = prod_signed[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: final_val = prod_signed[2*WIDTH-1:WIDTH];
            3'b100, 3'b101:         final_val = quo_signed;
            default:                final_val = rem_signed;
        endcase

        // Divide-by-zero and overflow have architecturally fixed results that
        // the sign-fix path would otherwise get wrong (e.g. signed DIV by 0).
        if (special_hit) begin
            final_val = special_val;
        end
    end

    // ------------------------------------------------------------------------
    // Control registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            op          <= 3'b000;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            special_hit <= 1'b0;
            special_val <= '0;
            cnt         <= '0;
        end else if (accept) begin
            op          <= func3;
            neg_q       <= a_neg ^ b_neg;
            neg_r       <= a_neg;
            special_hit <= special_now;
            special_val <= special_val_now;
            cnt         <= '0;
        end else if (state == CALC) begin
            cnt <= cnt + CW'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------------
    // NOTE: acc and operand carry no reset; they are always loaded on the
    // accept edge before being read, and reset only has to stop the FSM.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (is_div) begin
                acc     <= {{WIDTH{1'b0}}, a_mag};
                operand <= b_mag;
            end else begin
                acc     <= {{WIDTH{1'b0}}, b_mag};
                operand <= a_mag;
            end
        end else if (state == CALC) begin
            acc <= acc_next;
        end
    end

    // ------------------------------------------------------------------------
    // Registered result and zero flag; held through DONE until popped
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= '0;
            zero   <= 1'b1;
        end else if (calc_last) begin
            result <= final_val;
            zero   <= (final_val == '0);
        end
`ifdef ALU_MULDIV_EARLY_OUT_EN
        else if (accept && special_now) begin
            result <= special_val_now;
            zero   <= (special_val_now == '0);
        end
`endif
    end

endmodule

// File: tb/tb_alu_muldiv.sv
// ----------------------------------------------------------------------------
// tb_alu_muldiv
//
// Self-checking bench for alu_muldiv (WIDTH = 32): directed vector table,
// randomized operations against a 64-bit arithmetic reference model,
// backpressure and mid-operation reset sequences. Expected latency follows
// ALU_MULDIV_EARLY_OUT_EN when it is defined for the build.
// ----------------------------------------------------------------------------
module tb_alu_muldiv;

    localparam int W       = 32;
    localparam int TIMEOUT = 100;
    localparam logic [W-1:0] MIN_INT = 32'h8000_0000;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in1;
    logic [W-1:0] in2;
    logic [2:0]   func3;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] result;
    logic         zero;
    logic         busy;

    int n_checks = 0;
    int n_errors = 0;

    alu_muldiv #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in1       (in1),
        .in2       (in2),
        .func3     (func3),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Reference model: RV32M semantics computed with 64-bit arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'b0, a};
        ub = {32'b0, b};
        case (f)
            3'b000: begin p = 64'(sa * sb);          return p[31:0];  end
            3'b001: begin p = 64'(sa * sb);          return p[63:32]; end
            3'b010: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'b011: begin p = ua * ub;               return p[63:32]; end
            3'b100: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return a;
                p = 64'(sa / sb); return p[31:0];
            end
            3'b101: begin
                if (b == 0) return 32'hFFFF_FFFF;
                p = ua / ub; return p[31:0];
            end
            3'b110: begin
                if (b == 0) return a;
                if (a == MIN_INT && b == 32'hFFFF_FFFF) return 32'h0;
                p = 64'(sa % sb); return p[31:0];
            end
            default: begin
                if (b == 0) return a;
                p = ua % ub; return p[31:0];
            end
        endcase
    endfunction

    // Expected number of edges after the accept edge before out_valid reads high.
    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic special;
        if (f[2]) special = (b == 0) || (!f[0] && a == MIN_INT && b == 32'hFFFF_FFFF);
        else      special = (a == 0) || (b == 0);
`ifdef ALU_MULDIV_EARLY_OUT_EN
        return special ? 0 : W;
`else
        return (special && 1'b0) ? 0 : W;
`endif
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'hFFFF_FFFF;
            2:       return MIN_INT;
            3:       return 32'($urandom_range(1, 15));
            default: return $urandom();
        endcase
    endfunction

    // Issue one operation from IDLE, wait for the result, pop it.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          output logic [31:0] r, output logic z, output int lat);
        check("in_ready_before_op", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        func3    = f;
        in1      = a;
        in2      = b;
        @(negedge clk);                 // accept edge has passed
        in_valid = 1'b0;
        in1      = $urandom();
        in2      = $urandom();
        func3    = 3'($urandom());
        lat      = 0;
        while (!out_valid && lat < TIMEOUT) begin
            @(negedge clk);
            lat++;
        end
        r = result;
        z = zero;
        out_ready = 1'b1;
        @(negedge clk);                 // pop edge has passed
        out_ready = 1'b0;
        check("out_valid_after_pop", 32'(out_valid), 32'd0);
    endtask

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        z;
    } vec_t;

    vec_t vecs[$];

    initial begin
        logic [31:0] r;
        logic        z;
        int          lat;
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_r;
        int          n;

        vecs.push_back('{3'b000, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0});
        vecs.push_back('{3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0});
        vecs.push_back('{3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0});
        vecs.push_back('{3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'b001, 32'hFFFF_FFFF, 32'd1,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'b100, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 1'b0});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'b101, 32'd100,       32'd7,         32'd14,        1'b0});
        vecs.push_back('{3'b111, 32'd100,       32'd7,         32'd2,         1'b0});
        vecs.push_back('{3'b101, 32'd5,         32'd0,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'b111, 32'd5,         32'd0,         32'd5,         1'b0});
        vecs.push_back('{3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0});
        vecs.push_back('{3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1'b1});
        vecs.push_back('{3'b100, 32'd7,         32'd0,         32'hFFFF_FFFF, 1'b0});
        vecs.push_back('{3'b110, 32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 1'b0});
        vecs.push_back('{3'b000, 32'd0,         32'd5,         32'h0,         1'b1});
        vecs.push_back('{3'b011, 32'h1234_5678, 32'd0,         32'h0,         1'b1});
        vecs.push_back('{3'b111, 32'd21,        32'd7,         32'h0,         1'b1});

        rst       = 1'b1;
        in_valid  = 1'b0;
        in1       = '0;
        in2       = '0;
        func3     = 3'b000;
        out_ready = 1'b0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_in_ready",  32'(in_ready),  32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_result",    result,         32'd0);
        check("reset_zero",      32'(zero),      32'd1);
        check("reset_busy",      32'(busy),      32'd0);

        // ---------------- directed table ----------------
        foreach (vecs[i]) begin
            run_op(vecs[i].f, vecs[i].a, vecs[i].b, r, z, lat);
            check($sformatf("vec%0d_result", i), r, vecs[i].r);
            check($sformatf("vec%0d_zero", i), 32'(z), 32'(vecs[i].z));
            check($sformatf("vec%0d_latency", i), 32'(lat), 32'(exp_lat(vecs[i].f, vecs[i].a, vecs[i].b)));
        end

        // ---------------- randomized vs reference model ----------------
        for (int k = 0; k < 40; k++) begin
            f = 3'($urandom());
            a = pick_operand();
            b = pick_operand();
            exp_r = ref_model(f, a, b);
            run_op(f, a, b, r, z, lat);
            check($sformatf("rand%0d_f%0d_%h_%h_result", k, f, a, b), r, exp_r);
            check($sformatf("rand%0d_zero", k), 32'(z), 32'(exp_r == 0));
            check($sformatf("rand%0d_latency", k), 32'(lat), 32'(exp_lat(f, a, b)));
        end

        // ---------------- backpressure ----------------
        check("bp_in_ready_start", 32'(in_ready), 32'd1);
        in_valid = 1'b1; func3 = 3'b101; in1 = 32'd1000; in2 = 32'd3;
        @(negedge clk);
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        check("bp_out_valid_seen", 32'(out_valid), 32'd1);
        for (int c = 0; c < 10; c++) begin
            // stray requests while the result is waiting must be ignored
            in_valid = (c == 2 || c == 6);
            func3    = 3'b000;
            in1      = $urandom();
            in2      = $urandom();
            @(negedge clk);
            check($sformatf("bp%0d_out_valid", c), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_in_ready", c),  32'(in_ready),  32'd0);
            check($sformatf("bp%0d_result", c),    result,         32'd333);
            check($sformatf("bp%0d_zero", c),      32'(zero),      32'd0);
        end
        // pop cycle with in_valid high: must not be accepted
        out_ready = 1'b1;
        in_valid  = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("bp_in_ready_after_pop",  32'(in_ready),  32'd1);
        check("bp_busy_after_pop",      32'(busy),      32'd0);
        check("bp_out_valid_after_pop", 32'(out_valid), 32'd0);
        @(negedge clk);
        check("bp_idle_stays_idle", 32'(busy), 32'd0);

        // ---------------- reset in the middle of a divide ----------------
        in_valid = 1'b1; func3 = 3'b100; in1 = 32'hFFFF_FF00; in2 = 32'd5;
        @(negedge clk);                 // CALC cycle 1
        in_valid = 1'b0;
        repeat (9) @(negedge clk);      // CALC cycle 10
        check("mid_busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_in_ready",  32'(in_ready),  32'd1);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result",    result,         32'd0);
        check("mid_rst_zero",      32'(zero),      32'd1);
        check("mid_rst_busy",      32'(busy),      32'd0);
        repeat (W + 4) @(negedge clk);
        check("mid_rst_no_stray_result", 32'(out_valid), 32'd0);
        run_op(3'b000, 32'd3, 32'd4, r, z, lat);
        check("post_rst_mul_result",  r,          32'd12);
        check("post_rst_mul_zero",    32'(z),     32'd0);
        check("post_rst_mul_latency", 32'(lat),   32'(W));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
